// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and widths for the OBI data-memory responder.
package cv32e40p_obi_resp_pkg;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);
  localparam int unsigned LAT_W = 8;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [31:0]      rdata64;
    logic             err;
    logic [LAT_W-1:0] countdown;
  } resp_entry_t;

  typedef enum logic {
    GNT_IDLE,
    GNT_STALL
  } gnt_state_e;

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO; every entry counts down each cycle and the head pops at zero.
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  output logic        pop_o,
  output resp_entry_t head_o,
  output logic        full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      entry_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_o = entry_q[rd_ptr_q];
  assign pop_o  = (count_q != '0) && (head_o.countdown == '0);
  assign full_o = (count_q == CNT_W'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_o)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_o)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_o) count_q <= count_q - 1'b1;
    end
  end

  // The countdown also ticks in the push cycle, so a pushed value of L
  // pops exactly L cycles after the push.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_q[i].countdown != '0) entry_q[i].countdown <= entry_q[i].countdown - 1'b1;
    end
    if (push_i) begin
      entry_q[wr_ptr_q] <= '{rdata:     push_entry_i.rdata,
                             rdata64:   push_entry_i.rdata64,
                             err:       push_entry_i.err,
                             countdown: push_entry_i.countdown - LAT_W'(1)};
    end
  end

endmodule

// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-memory responder with 64-bit companion channel.
// Optional error response enabled by CV32E40P_OBI_RESP_ERR_EN.
module cv32e40p_obi_data_responder
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int unsigned MEM_WORDS        = 1024,
  parameter int unsigned MAX_OUTSTANDING  = 2,
  parameter int unsigned RVALID_LATENCY   = 1,
  parameter int unsigned GNT_STALL_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_req64_i,
  input  logic        data_we64_i,
  input  logic [31:0] data_addr64_i,
  input  logic [31:0] data_wdata64_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [31:0] data_rdata64_o
`ifdef CV32E40P_OBI_RESP_ERR_EN
  ,output logic       data_err_o
`endif
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned STALL_W = (GNT_STALL_CYCLES > 0) ? $clog2(GNT_STALL_CYCLES + 1) : 1;

  gnt_state_e         state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               gnt, full, hs, pop, err;
  logic [IDX_W-1:0]   idx0, idx64;
  logic [31:0]        rd0, rd64;
  logic [31:0]        rdata_q, rdata64_q;
  logic [31:0]        mem_q [MEM_WORDS];
  resp_entry_t        head, push_entry;
  logic               unused_bits;

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    gnt     = 1'b0;
    if (GNT_STALL_CYCLES == 0) begin
      gnt = data_req_i && !full;
    end else begin
      case (state_q)
        GNT_IDLE: begin
          if (data_req_i) begin
            state_d = GNT_STALL;
            stall_d = STALL_W'(GNT_STALL_CYCLES);
          end
        end
        GNT_STALL: begin
          if (!data_req_i) begin
            state_d = GNT_IDLE;
            stall_d = '0;
          end else if (stall_q <= STALL_W'(1)) begin
            // Counter has expired; wait here at zero while the FIFO is full.
            stall_d = '0;
            gnt     = !full;
            if (!full) state_d = GNT_IDLE;
          end else begin
            stall_d = stall_q - 1'b1;
          end
        end
        default: state_d = GNT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GNT_IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign data_gnt_o = gnt && !rst_i;
  assign hs         = data_req_i && data_gnt_o;
  assign idx0       = data_addr_i[2 +: IDX_W];
  assign idx64      = data_addr64_i[2 +: IDX_W];

`ifdef CV32E40P_OBI_RESP_ERR_EN
  assign err = (|data_addr_i[31:IDX_W+2]) || (data_req64_i && (|data_addr64_i[31:IDX_W+2]));
  assign unused_bits = ^{data_addr_i[1:0], data_addr64_i[1:0], head.countdown};
`else
  assign err = 1'b0;
  assign unused_bits = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0], data_addr64_i[31:IDX_W+2],
                         data_addr64_i[1:0], head.err, head.countdown};
`endif

  assign rd0  = (data_we_i || err) ? '0 : mem_q[idx0];
  assign rd64 = (!data_req64_i || data_we64_i || err) ? '0 : mem_q[idx64];

  // Companion write is issued last so it wins when both words hit one index.
  always_ff @(posedge clk_i) begin
    if (hs && !err) begin
      if (data_we_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (data_be_i[b]) mem_q[idx0][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
      if (data_req64_i && data_we64_i) mem_q[idx64] <= data_wdata64_i;
    end
  end

  assign push_entry = '{rdata: rd0, rdata64: rd64, err: err, countdown: LAT_W'(RVALID_LATENCY)};

  cv32e40p_obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (hs),
    .push_entry_i (push_entry),
    .pop_o        (pop),
    .head_o       (head),
    .full_o       (full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      rdata64_q <= '0;
    end else if (pop) begin
      rdata_q   <= head.rdata;
      rdata64_q <= head.rdata64;
    end
  end

  assign data_rvalid_o  = pop;
  assign data_rdata_o   = pop ? head.rdata : rdata_q;
  assign data_rdata64_o = pop ? head.rdata64 : rdata64_q;
`ifdef CV32E40P_OBI_RESP_ERR_EN
  assign data_err_o = pop && head.err;
`endif

endmodule

// File: tb/tb_cv32e40p_obi_data_responder.sv
// Directed bench: single-transaction vector table plus full, reset and grant-stall sequences.
module tb_cv32e40p_obi_data_responder;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, we, req64, we64, gnt, rvalid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, addr64, wdata64, rdata, rdata64;
  logic        b_req, b_we, b_gnt, b_rvalid;
  logic [31:0] b_wdata, b_rdata, b_rdata64;
`ifdef CV32E40P_OBI_RESP_ERR_EN
  logic        err, b_err;
`endif

  cv32e40p_obi_data_responder #(
    .MEM_WORDS(1024), .MAX_OUTSTANDING(2), .RVALID_LATENCY(LAT), .GNT_STALL_CYCLES(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata), .data_req64_i(req64),
    .data_we64_i(we64), .data_addr64_i(addr64), .data_wdata64_i(wdata64),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_rdata64_o(rdata64)
`ifdef CV32E40P_OBI_RESP_ERR_EN
    , .data_err_o(err)
`endif
  );

  cv32e40p_obi_data_responder #(
    .MEM_WORDS(16), .MAX_OUTSTANDING(1), .RVALID_LATENCY(1), .GNT_STALL_CYCLES(2)
  ) dut_stall (
    .clk_i(clk), .rst_i(rst), .data_req_i(b_req), .data_gnt_o(b_gnt), .data_addr_i(32'h0),
    .data_we_i(b_we), .data_be_i(4'hF), .data_wdata_i(b_wdata), .data_req64_i(1'b0),
    .data_we64_i(1'b0), .data_addr64_i(32'h0), .data_wdata64_i(32'h0),
    .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata), .data_rdata64_o(b_rdata64)
`ifdef CV32E40P_OBI_RESP_ERR_EN
    , .data_err_o(b_err)
`endif
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        req64, we64;
    logic [31:0] addr64, wdata64;
    logic [31:0] exp0, exp64;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v64(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                               input logic r64, input logic w64, input logic [31:0] a64, input logic [31:0] d64,
                               input logic [31:0] e0, input logic [31:0] e64);
    vec_t v;
    v = '{we: w, be: b, addr: a, wdata: d, req64: r64, we64: w64, addr64: a64, wdata64: d64,
          exp0: e0, exp64: e64, exp_err: 1'b0};
    return v;
  endfunction

  function automatic vec_t v32(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] e0);
    return v64(w, b, a, d, 1'b0, 1'b0, 32'h0, 32'h0, e0, 32'h0);
  endfunction

  task automatic txn(input vec_t v, input string tag);
    int n;
    int lat;
    @(negedge clk);
    we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    req64 = v.req64; we64 = v.we64; addr64 = v.addr64; wdata64 = v.wdata64; req = 1'b1;
    #1;
    n = 0;
    while (!gnt && n < 20) begin @(negedge clk); #1; n++; end
    check($sformatf("%s_gnt", tag), 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0; we = 1'b0; req64 = 1'b0; we64 = 1'b0; be = '0;
    #1;
    lat = 1;
    while (!rvalid && lat < 20) begin @(negedge clk); #1; lat++; end
    check($sformatf("%s_lat", tag), 32'(lat), 32'(LAT));
    check($sformatf("%s_rdata", tag), rdata, v.exp0);
    check($sformatf("%s_rdata64", tag), rdata64, v.exp64);
`ifdef CV32E40P_OBI_RESP_ERR_EN
    check($sformatf("%s_err", tag), 32'(err), 32'(v.exp_err));
`endif
    @(negedge clk); #1;
    check($sformatf("%s_rv_once", tag), 32'(rvalid), 32'd0);
    check($sformatf("%s_hold", tag), rdata, v.exp0);
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        tmp;
    logic [31:0] f_addr [3];
    logic [31:0] f_exp  [3];
    bit          f_gnt  [11];
    bit          f_rv   [11];
    int          nxt, nrv, rv_seen;
    bit          b_r [10], b_g [10], b_v [10];

    rst = 1'b1; req = 1'b1; we = 1'b0; be = '0; addr = '0; wdata = '0;
    req64 = 1'b0; we64 = 1'b0; addr64 = '0; wdata64 = '0;
    b_req = 1'b0; b_we = 1'b0; b_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_rdata64", rdata64, 32'd0);
    req = 1'b0;
    @(negedge clk); rst = 1'b0;

    vecs.push_back(v32(1'b1, 4'hF, 32'h10, 32'h1111_1111, 32'h0));
    vecs.push_back(v32(1'b1, 4'h3, 32'h10, 32'hAABB_CCDD, 32'h0));
    vecs.push_back(v32(1'b0, 4'h0, 32'h10, 32'h0, 32'h1111_CCDD));
    vecs.push_back(v64(1'b1, 4'hF, 32'h20, 32'h1, 1'b1, 1'b1, 32'h24, 32'h2, 32'h0, 32'h0));
    vecs.push_back(v64(1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 32'h1, 32'h2));
    vecs.push_back(v32(1'b0, 4'h0, 32'h24, 32'h0, 32'h2));
    vecs.push_back(v64(1'b1, 4'hF, 32'h30, 32'hDEAD_0000, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 32'h0, 32'h0));
    vecs.push_back(v32(1'b0, 4'h0, 32'h30, 32'h0, 32'h1234_5678));
    vecs.push_back(v64(1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h1111_CCDD, 32'h0));
    vecs.push_back(v32(1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFE_F00D));
    vecs.push_back(v32(1'b1, 4'h8, 32'h10, 32'h9900_0000, 32'h0));
    vecs.push_back(v32(1'b0, 4'h0, 32'h10, 32'h0, 32'h9911_CCDD));
`ifdef CV32E40P_OBI_RESP_ERR_EN
    vecs.push_back(v32(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D, 32'h0));
    tmp = v32(1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, 32'h0); tmp.exp_err = 1'b1;
    vecs.push_back(tmp);
    vecs.push_back(v32(1'b0, 4'h0, 32'h0, 32'h0, 32'h0BAD_F00D));
    tmp = v32(1'b0, 4'h0, 32'h1000, 32'h0, 32'h0); tmp.exp_err = 1'b1;
    vecs.push_back(tmp);
`else
    tmp = v32(1'b1, 4'hF, 32'h1014, 32'h5A5A_5A5A, 32'h0);
    vecs.push_back(tmp);
    vecs.push_back(v32(1'b0, 4'h0, 32'h14, 32'h0, 32'h5A5A_5A5A));
`endif
    foreach (vecs[i]) txn(vecs[i], $sformatf("v%0d", i));

    // Back-to-back reads with req held: third grant waits for the first pop.
    f_addr = '{32'h10, 32'h30, 32'h40};
    f_exp  = '{32'h9911_CCDD, 32'h1234_5678, 32'hCAFE_F00D};
    f_gnt  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    f_rv   = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    nxt = 0; nrv = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = f_addr[0];
    #1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      check($sformatf("full_gnt_c%0d", k), 32'(gnt), 32'(f_gnt[k]));
      check($sformatf("full_rv_c%0d", k), 32'(rvalid), 32'(f_rv[k]));
      if (rvalid && nrv < 3) begin
        check($sformatf("full_order%0d", nrv), rdata, f_exp[nrv]);
        nrv++;
      end
      if (req && gnt) begin
        // handshake completes at the next posedge; advance after it
        @(posedge clk); #1;
        nxt++;
        if (nxt < 3) addr = f_addr[nxt];
        else req = 1'b0;
      end
    end

    // Reset with two transactions outstanding.
    @(negedge clk); req = 1'b1; addr = 32'h10;
    @(negedge clk); addr = 32'h30;
    @(negedge clk); req = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    rv_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rvalid) rv_seen++;
    end
    check("rst_mid_no_rvalid", 32'(rv_seen), 32'd0);
    txn(v32(1'b0, 4'h0, 32'h10, 32'h0, 32'h9911_CCDD), "rst_mem0");
    txn(v64(1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 32'hCAFE_F00D), "rst_mem1");

    // Grant stall of 2: write then read, second request interrupted once.
    b_r = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    b_g = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    b_v = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      b_req = b_r[k]; b_we = (k < 4); b_wdata = 32'h77;
      #1;
      check($sformatf("stall_gnt_c%0d", k), 32'(b_gnt), 32'(b_g[k]));
      check($sformatf("stall_rv_c%0d", k), 32'(b_rvalid), 32'(b_v[k]));
      if (k == 3) check("stall_wr_rdata", b_rdata, 32'h0);
      if (k == 9) begin
        check("stall_rd_rdata", b_rdata, 32'h77);
        check("stall_rd_rdata64", b_rdata64, 32'h0);
`ifdef CV32E40P_OBI_RESP_ERR_EN
        check("stall_rd_err", 32'(b_err), 32'd0);
`endif
      end
    end
    b_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
